vga_timing_gen: RTL

Parametrised successor to the fixed-mode VGA sync generator. Produces hsync, vsync and data-enable for any VESA-style mode, plus frame-buffer read addresses. Sync and DE are delayed by a configurable pipeline depth so they line up with pixel data returned by the frame-buffer read path. Also adds a run/stop enable, a frame counter and a programmable line interrupt; sits between the pixel clock domain and the frame-buffer reader.

---
 rtl/vga_timing_gen.sv | 105 ++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VESA-style sync/DE generator with frame-buffer addresses, frame counter and line irq
module vga_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 144,
  parameter int H_BP     = 248,
  parameter int V_ACTIVE = 1024,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 38,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int V_FLIP   = 1,
  parameter int PIPE_DLY = 2,
  parameter int HADDR_W  = 12,
  parameter int VADDR_W  = 11,
  parameter int FRAME_W  = 16
) (
  input  logic               px_clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [VADDR_W-1:0] line_irq_line,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [HADDR_W-1:0] h_addr,
  output logic [VADDR_W-1:0] v_addr,
  output logic               frame_start,
  output logic               line_irq,
  output logic [FRAME_W-1:0] frame_count
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);
  localparam logic [2:0] TIM_IDLE = {~HS_ON, ~VS_ON, 1'b0};

  if (H_ACTIVE > 2**HADDR_W || V_ACTIVE > 2**VADDR_W || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_FP < 1 || V_SYNC < 1 || V_BP < 1 || PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_param_check
    $error("vga_timing_gen: invalid parameter set");
  end

  logic [HW-1:0]      h_cnt_q, h_cnt_d;
  logic [VW-1:0]      v_cnt_q, v_cnt_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [HADDR_W-1:0] h_addr_q, h_addr_d;
  logic [VADDR_W-1:0] v_addr_q, v_addr_d;
  logic               fs_q, fs_d, irq_q, irq_d;
  logic [2:0]         tim_q [0:PIPE_DLY];
  logic [2:0]         tim_d [0:PIPE_DLY];
  logic [31:0]        hc, vc;
  logic               h_last, v_last, h_act, v_act, hs_in, vs_in;

  always_comb begin
    hc = 32'(h_cnt_q);
    vc = 32'(v_cnt_q);
    h_last = hc == H_TOTAL - 1;
    v_last = vc == V_TOTAL - 1;
    h_act = hc < H_ACTIVE;
    v_act = vc < V_ACTIVE;
    hs_in = hc >= H_ACTIVE + H_FP && hc < H_ACTIVE + H_FP + H_SYNC;
    vs_in = vc >= V_ACTIVE + V_FP && vc < V_ACTIVE + V_FP + V_SYNC;
    h_cnt_d = !enable || h_last ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = !enable ? '0 : !h_last ? v_cnt_q : v_last ? '0 : v_cnt_q + 1'b1;
    frame_cnt_d = enable && h_last && v_last ? frame_cnt_q + 1'b1 : frame_cnt_q;
    h_addr_d = enable && h_act ? HADDR_W'(hc) : '0;
    v_addr_d = !(enable && v_act) ? '0 : V_FLIP != 0 ? VADDR_W'(V_ACTIVE - 1 - vc) : VADDR_W'(vc);
    fs_d = enable && hc == 0 && vc == 0;
    irq_d = enable && hc == H_ACTIVE && vc == 32'(line_irq_line);
    // stage 0 is aligned with the address registers; later stages only delay it
    tim_d[0] = enable ? {hs_in ? HS_ON : ~HS_ON, vs_in ? VS_ON : ~VS_ON, h_act && v_act} : TIM_IDLE;
    for (int i = 1; i <= PIPE_DLY; i++) tim_d[i] = tim_q[i-1];
  end

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      frame_cnt_q <= '0;
      h_addr_q <= '0;
      v_addr_q <= '0;
      fs_q <= 1'b0;
      irq_q <= 1'b0;
      for (int i = 0; i <= PIPE_DLY; i++) tim_q[i] <= TIM_IDLE;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      h_addr_q <= h_addr_d;
      v_addr_q <= v_addr_d;
      fs_q <= fs_d;
      irq_q <= irq_d;
      tim_q <= tim_d;
    end
  end

  assign {hsync, vsync, de} = tim_q[PIPE_DLY];
  assign h_addr = h_addr_q;
  assign v_addr = v_addr_q;
  assign frame_start = fs_q;
  assign line_irq = irq_q;
  assign frame_count = frame_cnt_q;
endmodule
